// File: rtl/tree_pkg.sv
// -----------------------------------------------------------------------------
// tree_pkg
// Shared types for the tree walker: the child-table entry, the table and ROM
// shapes, the error codes and the FSM states. It also holds the generator
// functions that expand user_tree_pkg::dependencies into per-slot table entries
// and ROM words.
// -----------------------------------------------------------------------------
package tree_pkg;

   localparam int TREE_ID_W         = 8;
   localparam int TREE_NODE_AW      = 6;
   localparam int TREE_MAX_CHILDREN = 4;
   localparam int TREE_MAX_DEPTH    = 8;
   localparam int TREE_DATA_W       = 32;
   localparam int TREE_NODES        = 2 ** TREE_NODE_AW;

   typedef struct packed {
      logic                    valid;
      logic [TREE_ID_W-1:0]    id;
      logic [TREE_NODE_AW-1:0] addr;
   } child_entry_t;

   typedef child_entry_t child_table_t [TREE_NODES][TREE_MAX_CHILDREN];
   typedef logic [TREE_DATA_W-1:0] node_rom_t [TREE_NODES];

   typedef enum logic [1:0] {
      ERR_OK        = 2'd0,
      ERR_NO_CHILD  = 2'd1,
      ERR_OVERFLOW  = 2'd2,
      ERR_UNDERFLOW = 2'd3
   } err_t;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SEARCH = 2'd1,
      S_READ   = 2'd2,
      S_OUT    = 2'd3
   } walker_state_t;

   // Child-table slot (node, slot). Slots that no edge names stay invalid.
   function automatic child_entry_t child_entry(input int node, input int slot);
      child_entry_t e;
      e = '0;
      for (int k = 0; k < user_tree_pkg::NUM_DEPS; k++) begin
         if (user_tree_pkg::dependencies[k].parent == node &&
             user_tree_pkg::dependencies[k].slot == slot) begin
            e.valid = 1'b1;
            e.id    = TREE_ID_W'(user_tree_pkg::dependencies[k].id);
            e.addr  = TREE_NODE_AW'(user_tree_pkg::dependencies[k].child);
         end
      end
      return e;
   endfunction

   function automatic logic [TREE_DATA_W-1:0] node_record(input int node);
      return TREE_DATA_W'(user_tree_pkg::node_data(node));
   endfunction

endpackage

// File: rtl/user_tree_pkg.sv
// -----------------------------------------------------------------------------
// user_tree_pkg
// Tree content only: the parent/slot/id/child edge list the walker navigates and
// the per-node data record. tree_pkg turns this into the hardware tables.
// Root is node 0. The chain 0 -(02)-> 2 -(40)-> 10 -> 11 ... -> 17 is deeper
// than the walker's stack. Node 5 holds the same id in two slots, and some slots
// are left empty on purpose.
// -----------------------------------------------------------------------------
package user_tree_pkg;

   typedef struct packed {
      int parent;
      int slot;
      int id;
      int child;
   } dep_t;

   localparam int NUM_DEPS = 18;

   localparam dep_t dependencies [NUM_DEPS] = '{
      '{0, 0, 'h01, 1},
      '{0, 1, 'h02, 2},
      '{0, 2, 'h11, 5},
      '{0, 3, 'h22, 3},
      '{1, 0, 'h10, 4},
      '{5, 0, 'h31, 6},
      '{5, 1, 'h31, 7},
      '{3, 0, 'h05, 8},
      '{3, 2, 'h06, 9},
      '{8, 3, 'h07, 20},
      '{2, 0, 'h40, 10},
      '{10, 0, 'h40, 11},
      '{11, 0, 'h40, 12},
      '{12, 1, 'h40, 13},
      '{13, 0, 'h40, 14},
      '{14, 0, 'h40, 15},
      '{15, 3, 'h40, 16},
      '{16, 0, 'h40, 17}
   };

   // Record payload per node. An odd multiplier keeps every node's record distinct.
   function automatic logic [31:0] node_data(input int n);
      return 32'hA5C3_0000 ^ (32'(n) * 32'h0013_0107);
   endfunction

endpackage

// File: rtl/node_stack.sv
// -----------------------------------------------------------------------------
// node_stack
// LIFO holding the parent addresses of the current walk.
// Ports: clk_i/reset_i (async active-low), clear_i (sync empty), push_i/pop_i,
//        push_data_i, top_o (most recent entry), level_o (entry count),
//        full_o, empty_o.
// The caller must not push while full or pop while empty. Assertions flag any
// such access.
// -----------------------------------------------------------------------------
module node_stack #(
   parameter int AW    = 6,
   parameter int DEPTH = 8,
   parameter int LW    = $clog2(DEPTH + 1)
) (
   input  logic          clk_i,
   input  logic          reset_i,
   input  logic          clear_i,
   input  logic          push_i,
   input  logic          pop_i,
   input  logic [AW-1:0] push_data_i,
   output logic [AW-1:0] top_o,
   output logic [LW-1:0] level_o,
   output logic          full_o,
   output logic          empty_o
);

   localparam int IW = $clog2(DEPTH);

   logic [AW-1:0] mem_q [DEPTH];
   logic [LW-1:0] sp_q;
   logic [LW-1:0] sp_m1;

   assign sp_m1   = sp_q - LW'(1);
   assign top_o   = mem_q[sp_m1[IW-1:0]];
   assign level_o = sp_q;
   assign full_o  = (sp_q == LW'(DEPTH));
   assign empty_o = (sp_q == '0);

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         sp_q <= '0;
      end else if (clear_i) begin
         sp_q <= '0;
      end else if (push_i && !full_o) begin
         sp_q <= sp_q + LW'(1);
      end else if (pop_i && !empty_o) begin
         sp_q <= sp_m1;
      end
   end

   // Storage needs no reset: only entries below sp_q are ever read.
   always_ff @(posedge clk_i) begin
      if (push_i && !full_o && !clear_i) begin
         mem_q[sp_q[IW-1:0]] <= push_data_i;
      end
   end

   a_no_overflow:  assert property (@(posedge clk_i) disable iff (!reset_i) !(push_i && full_o));
   a_no_underflow: assert property (@(posedge clk_i) disable iff (!reset_i) !(pop_i && empty_o));
   a_one_op:       assert property (@(posedge clk_i) disable iff (!reset_i) !(push_i && pop_i));

endmodule

// File: rtl/node_tree_walker.sv
// -----------------------------------------------------------------------------
// node_tree_walker
// Walks the constant tree from tree_pkg, one request at a time. A request is
// either a field id or a pop. Each request yields one node record and an error
// code.
// Ports: clk_i, reset_i (async active-low);
//        request side:  field_id_i, field_pop_i, field_id_valid, field_id_rdy;
//        restart_i: synchronous return to the root, abandoning any request;
//        result side:   node_valid, node_rdy, node_o, node_addr_o,
//                       node_depth_o, node_err_o.
// Latency: for a handshake at edge T, node_valid is high from edge T+3.
// -----------------------------------------------------------------------------
module node_tree_walker
   import tree_pkg::*;
#(
   parameter int ID_W         = TREE_ID_W,
   parameter int NODE_AW      = TREE_NODE_AW,
   parameter int MAX_CHILDREN = TREE_MAX_CHILDREN,
   parameter int MAX_DEPTH    = TREE_MAX_DEPTH,
   parameter int DATA_W       = TREE_DATA_W,
   parameter int DEPTH_W      = $clog2(MAX_DEPTH + 1)
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic [ID_W-1:0]    field_id_i,
   input  logic               field_pop_i,
   input  logic               field_id_valid,
   output logic               field_id_rdy,
   input  logic               restart_i,
   output logic               node_valid,
   input  logic               node_rdy,
   output logic [DATA_W-1:0]  node_o,
   output logic [NODE_AW-1:0] node_addr_o,
   output logic [DEPTH_W-1:0] node_depth_o,
   output logic [1:0]         node_err_o
);

   walker_state_t        state_q;
   logic                 rdy_q;
   logic                 read_phase_q;
   logic [ID_W-1:0]      id_q;
   logic                 pop_q;
   logic [NODE_AW-1:0]   cur_addr_q;
   err_t                 err_q;
   logic [TREE_DATA_W-1:0] rom_q;
   logic                 node_valid_q;
   logic [DATA_W-1:0]    node_q;
   logic [NODE_AW-1:0]   node_addr_q;
   logic [DEPTH_W-1:0]   node_depth_q;
   err_t                 node_err_q;

   child_table_t child_tab;
   node_rom_t    node_rom;

   for (genvar gi = 0; gi < TREE_NODES; gi++) begin : g_node
      assign node_rom[gi] = node_record(gi);
      for (genvar gj = 0; gj < TREE_MAX_CHILDREN; gj++) begin : g_slot
         assign child_tab[gi][gj] = child_entry(gi, gj);
      end
   end

   // Compare every slot in parallel. Build the priority chain from the top slot
   // down, so the lowest matching slot decides the result.
   logic [MAX_CHILDREN-1:0] slot_hit;
   logic [NODE_AW-1:0]      chain_addr [MAX_CHILDREN+1];
   logic                    hit;
   logic [NODE_AW-1:0]      hit_addr;

   assign chain_addr[MAX_CHILDREN] = '0;
   for (genvar gi = 0; gi < MAX_CHILDREN; gi++) begin : g_cmp
      assign slot_hit[gi]   = child_tab[cur_addr_q][gi].valid &&
                              (ID_W'(child_tab[cur_addr_q][gi].id) == id_q);
      assign chain_addr[gi] = slot_hit[gi] ? NODE_AW'(child_tab[cur_addr_q][gi].addr)
                                           : chain_addr[gi+1];
   end
   assign hit      = |slot_hit;
   assign hit_addr = chain_addr[0];

   // Stack control. A restart in the SEARCH cycle cancels the update.
   logic               in_search;
   logic               do_push;
   logic               do_pop;
   logic               stk_full;
   logic               stk_empty;
   logic [NODE_AW-1:0] stk_top;
   logic [DEPTH_W-1:0] stk_level;
   err_t               search_err;

   assign in_search = (state_q == S_SEARCH) && !restart_i;
   assign do_push   = in_search && !pop_q && hit && !stk_full;
   assign do_pop    = in_search && pop_q && !stk_empty;

   always_comb begin
      search_err = ERR_OK;
      if (pop_q) begin
         if (stk_empty) search_err = ERR_UNDERFLOW;
      end else if (!hit) begin
         search_err = ERR_NO_CHILD;
      end else if (stk_full) begin
         search_err = ERR_OVERFLOW;
      end
   end

   node_stack #(
      .AW    (NODE_AW),
      .DEPTH (MAX_DEPTH),
      .LW    (DEPTH_W)
   ) u_stack (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .clear_i     (restart_i),
      .push_i      (do_push),
      .pop_i       (do_pop),
      .push_data_i (cur_addr_q),
      .top_o       (stk_top),
      .level_o     (stk_level),
      .full_o      (stk_full),
      .empty_o     (stk_empty)
   );

   // Block-ROM style registered read, addressed by the already-updated cur_addr.
   always_ff @(posedge clk_i) begin
      rom_q <= node_rom[cur_addr_q];
   end

   // READ lasts two cycles. The first covers the ROM read latency. The second
   // loads the output registers, so OUT begins three edges after the handshake.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         state_q      <= S_IDLE;
         rdy_q        <= 1'b0;
         read_phase_q <= 1'b0;
         id_q         <= '0;
         pop_q        <= 1'b0;
         cur_addr_q   <= '0;
         err_q        <= ERR_OK;
         node_valid_q <= 1'b0;
         node_q       <= '0;
         node_addr_q  <= '0;
         node_depth_q <= '0;
         node_err_q   <= ERR_OK;
      end else if (restart_i) begin
         state_q      <= S_IDLE;
         rdy_q        <= 1'b1;
         read_phase_q <= 1'b0;
         cur_addr_q   <= '0;
         node_valid_q <= 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               rdy_q <= 1'b1;
               if (field_id_valid && rdy_q) begin
                  id_q    <= field_id_i;
                  pop_q   <= field_pop_i;
                  rdy_q   <= 1'b0;
                  state_q <= S_SEARCH;
               end
            end
            S_SEARCH: begin
               if (do_push) begin
                  cur_addr_q <= hit_addr;
               end else if (do_pop) begin
                  cur_addr_q <= stk_top;
               end
               err_q   <= search_err;
               state_q <= S_READ;
            end
            S_READ: begin
               read_phase_q <= !read_phase_q;
               if (read_phase_q) begin
                  node_q       <= DATA_W'(rom_q);
                  node_addr_q  <= cur_addr_q;
                  node_depth_q <= stk_level;
                  node_err_q   <= err_q;
                  node_valid_q <= 1'b1;
                  state_q      <= S_OUT;
               end
            end
            S_OUT: begin
               if (node_rdy) begin
                  node_valid_q <= 1'b0;
                  rdy_q        <= 1'b1;
                  state_q      <= S_IDLE;
               end
            end
         endcase
      end
   end

   assign field_id_rdy = rdy_q && !restart_i;
   assign node_valid   = node_valid_q;
   assign node_o       = node_q;
   assign node_addr_o  = node_addr_q;
   assign node_depth_o = node_depth_q;
   assign node_err_o   = node_err_q;

endmodule

// File: tb/tb_node_tree_walker.sv
module tb_node_tree_walker;
   import user_tree_pkg::*;

   localparam int MAX_DEPTH = 8;

   logic        clk = 1'b0;
   logic        reset_i = 1'b0;
   logic [7:0]  field_id_i = '0;
   logic        field_pop_i = 1'b0;
   logic        field_id_valid = 1'b0;
   logic        restart_i = 1'b0;
   logic        node_rdy = 1'b1;
   logic        field_id_rdy;
   logic        node_valid;
   logic [31:0] node_o;
   logic [5:0]  node_addr_o;
   logic [3:0]  node_depth_o;
   logic [1:0]  node_err_o;

   int vectors = 0;
   int miscompares = 0;

   // Reference walk state: current node and a queue of the parents above it.
   int m_cur = 0;
   int m_stack [$];
   int m_err = 0;

   logic [7:0] pool [12];

   always #5 clk = ~clk;

   node_tree_walker dut (
      .clk_i          (clk),
      .reset_i        (reset_i),
      .field_id_i     (field_id_i),
      .field_pop_i    (field_pop_i),
      .field_id_valid (field_id_valid),
      .field_id_rdy   (field_id_rdy),
      .restart_i      (restart_i),
      .node_valid     (node_valid),
      .node_rdy       (node_rdy),
      .node_o         (node_o),
      .node_addr_o    (node_addr_o),
      .node_depth_o   (node_depth_o),
      .node_err_o     (node_err_o)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_cur = 0;
      m_stack.delete();
   endtask

   task automatic model_step(input logic [7:0] id, input logic pop);
      int best_slot;
      int best_child;
      best_slot  = 1 << 30;
      best_child = -1;
      if (pop) begin
         if (m_stack.size() == 0) begin
            m_err = 3;
         end else begin
            m_cur = m_stack.pop_back();
            m_err = 0;
         end
      end else begin
         for (int k = 0; k < NUM_DEPS; k++) begin
            if (dependencies[k].parent == m_cur && dependencies[k].id == int'(id) &&
                dependencies[k].slot < best_slot) begin
               best_slot  = dependencies[k].slot;
               best_child = dependencies[k].child;
            end
         end
         if (best_child < 0) begin
            m_err = 1;
         end else if (m_stack.size() == MAX_DEPTH) begin
            m_err = 2;
         end else begin
            m_stack.push_back(m_cur);
            m_cur = best_child;
            m_err = 0;
         end
      end
   endtask

   task automatic wait_rdy();
      int n;
      n = 0;
      while (!field_id_rdy && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("rdy_wait", field_id_rdy, 1);
   endtask

   // Called at a negedge with field_id_rdy high; returns 1 ns after handshake edge T.
   task automatic handshake(input logic [7:0] id, input logic pop);
      field_id_i     = id;
      field_pop_i    = pop;
      field_id_valid = 1'b1;
      @(posedge clk);
      #1;
      field_id_valid = 1'b0;
   endtask

   task automatic collect(input int hold);
      logic [31:0] exp_rec;
      exp_rec = node_data(m_cur);
      if (hold > 0) node_rdy = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      chk("valid_early", node_valid, 0);
      @(negedge clk);
      chk("valid", node_valid, 1);
      chk("addr", node_addr_o, m_cur);
      chk("depth", node_depth_o, m_stack.size());
      chk("err", node_err_o, m_err);
      chk("record", node_o, exp_rec);
      chk("rdy_busy", field_id_rdy, 0);
      for (int c = 1; c < hold; c++) begin
         @(negedge clk);
         chk("hold_valid", node_valid, 1);
         chk("hold_addr", node_addr_o, m_cur);
         chk("hold_record", node_o, exp_rec);
         chk("hold_rdy", field_id_rdy, 0);
      end
      if (hold > 0) node_rdy = 1'b1;
      @(negedge clk);
      chk("rdy_back", field_id_rdy, 1);
      chk("valid_drop", node_valid, 0);
   endtask

   task automatic txn(input logic [7:0] id, input logic pop, input int hold);
      wait_rdy();
      handshake(id, pop);
      model_step(id, pop);
      collect(hold);
      $display("txn id=%02h pop=%0d -> addr=%0d depth=%0d err=%0d", id, pop,
               node_addr_o, node_depth_o, node_err_o);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      pool = '{8'h01, 8'h02, 8'h11, 8'h22, 8'h10, 8'h31,
               8'h40, 8'h05, 8'h06, 8'h07, 8'hEE, 8'h00};

      // Values while reset is asserted.
      @(negedge clk);
      @(negedge clk);
      chk("reset_rdy", field_id_rdy, 0);
      chk("reset_valid", node_valid, 0);
      chk("reset_record", node_o, 0);
      chk("reset_addr", node_addr_o, 0);
      chk("reset_depth", node_depth_o, 0);
      chk("reset_err", node_err_o, 0);
      reset_i = 1'b1;
      @(negedge clk);
      chk("rdy_after_reset", field_id_rdy, 1);

      // Single descent, miss, duplicate-id priority, empty-slot id 0, pops.
      txn(8'h11, 1'b0, 0);
      txn(8'hEE, 1'b0, 0);
      txn(8'h31, 1'b0, 0);
      txn(8'h00, 1'b1, 0);
      txn(8'h00, 1'b0, 0);
      txn(8'h00, 1'b1, 0);
      txn(8'h00, 1'b1, 0);
      txn(8'h01, 1'b1, 0);
      txn(8'h01, 1'b0, 0);

      // Restart while idle: the same-cycle handshake is refused and no output follows.
      field_id_i     = 8'h11;
      field_pop_i    = 1'b0;
      field_id_valid = 1'b1;
      restart_i      = 1'b1;
      #1;
      chk("restart_idle_rdy", field_id_rdy, 0);
      @(posedge clk);
      #1;
      restart_i      = 1'b0;
      field_id_valid = 1'b0;
      model_reset();
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("restart_idle_novalid", node_valid, 0);
      end
      txn(8'h00, 1'b1, 0);

      // Full-depth chain, one overflow, then unwind.
      txn(8'h02, 1'b0, 0);
      for (int i = 0; i < 7; i++) txn(8'h40, 1'b0, 0);
      txn(8'h40, 1'b0, 0);
      for (int i = 0; i < 8; i++) txn(8'h00, 1'b1, 0);

      // Consumer backpressure.
      txn(8'h11, 1'b0, 5);
      txn(8'h00, 1'b1, 0);

      // Restart during READ from depth 3.
      txn(8'h02, 1'b0, 0);
      txn(8'h40, 1'b0, 0);
      txn(8'h40, 1'b0, 0);
      wait_rdy();
      handshake(8'h40, 1'b0);
      @(negedge clk);
      @(negedge clk);
      restart_i = 1'b1;
      @(posedge clk);
      #1;
      restart_i = 1'b0;
      model_reset();
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("restart_read_novalid", node_valid, 0);
      end
      txn(8'h00, 1'b1, 0);
      txn(8'h11, 1'b0, 0);

      // Asynchronous reset in SEARCH.
      txn(8'h00, 1'b1, 0);
      txn(8'h22, 1'b0, 0);
      txn(8'h05, 1'b0, 0);
      wait_rdy();
      handshake(8'h07, 1'b0);
      @(negedge clk);
      reset_i = 1'b0;
      #1;
      chk("areset_valid", node_valid, 0);
      chk("areset_rdy", field_id_rdy, 0);
      chk("areset_addr", node_addr_o, 0);
      chk("areset_depth", node_depth_o, 0);
      chk("areset_record", node_o, 0);
      @(negedge clk);
      reset_i = 1'b1;
      model_reset();
      @(negedge clk);
      chk("areset_rdy_back", field_id_rdy, 1);
      txn(8'h00, 1'b1, 0);

      // Random walk against the reference model.
      for (int n = 0; n < 150; n++) begin
         logic [7:0] rid;
         logic       rpop;
         int         rhold;
         rid   = pool[$urandom_range(0, 11)];
         rpop  = ($urandom_range(0, 2) == 0);
         rhold = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
         txn(rid, rpop, rhold);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
